// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences each instruction
// through fetch/decode/execute/memory/writeback and counts retired instructions.
module multicycle_control #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           op,
  output logic                 pcwrite,
  output logic                 pcwritecond,
  output logic                 iord,
  output logic                 memread,
  output logic                 memwrite,
  output logic                 memtoreg,
  output logic                 irwrite,
  output logic                 regwrite,
  output logic                 regdst,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic [1:0]           pcsource,
  output logic                 aluop1,
  output logic                 aluop0,
  output logic                 illegal,
  output logic [3:0]           state,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t     state_reg;
  logic [5:0] op_reg;
  logic       op_known;

  always_comb begin
    op_known = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  end

  // Opcode is captured in DECODE so MEMADR can split lw/sw without re-reading op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_FETCH;
      op_reg    <= 6'd0;
      instret   <= '0;
    end else begin
      case (state_reg)
        S_FETCH:  state_reg <= S_DECODE;
        S_DECODE: begin
          op_reg <= op;
          case (op)
            OP_LW, OP_SW: state_reg <= S_MEMADR;
            OP_RTYPE:     state_reg <= S_EXEC;
            OP_BEQ:       state_reg <= S_BRANCH;
            OP_J:         state_reg <= S_JUMP;
            OP_ADDI:      state_reg <= S_ADDIEX;
            default:      state_reg <= S_FETCH;
          endcase
        end
        S_MEMADR: state_reg <= (op_reg == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  state_reg <= S_MEMWB;
        S_EXEC:   state_reg <= S_RTWB;
        S_ADDIEX: state_reg <= S_ADDIWB;
        S_MEMWB, S_MEMWR, S_RTWB, S_BRANCH, S_JUMP, S_ADDIWB: begin
          state_reg <= S_FETCH;
          instret   <= instret + 1'b1;
        end
        default:  state_reg <= S_FETCH;
      endcase
    end
  end

  assign state = state_reg;

  // Moore decode, gated by rst_n so writes drop the moment reset is asserted.
  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    memtoreg    = 1'b0;
    irwrite     = 1'b0;
    regwrite    = 1'b0;
    regdst      = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    pcsource    = 2'b00;
    aluop1      = 1'b0;
    aluop0      = 1'b0;
    illegal     = 1'b0;
    if (rst_n) begin
      case (state_reg)
        S_FETCH: begin
          memread = 1'b1;
          irwrite = 1'b1;
          pcwrite = 1'b1;
          alusrcb = 2'b01;
        end
        S_DECODE: begin
          alusrcb = 2'b11;
          illegal = !op_known;
        end
        S_MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_MEMRD: begin
          memread = 1'b1;
          iord    = 1'b1;
        end
        S_MEMWB: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
        end
        S_MEMWR: begin
          memwrite = 1'b1;
          iord     = 1'b1;
        end
        S_EXEC: begin
          alusrca = 1'b1;
          aluop1  = 1'b1;
        end
        S_RTWB: begin
          regwrite = 1'b1;
          regdst   = 1'b1;
        end
        S_BRANCH: begin
          alusrca     = 1'b1;
          aluop0      = 1'b1;
          pcwritecond = 1'b1;
          pcsource    = 2'b01;
        end
        S_JUMP: begin
          pcwrite  = 1'b1;
          pcsource = 2'b10;
        end
        S_ADDIEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_ADDIWB: regwrite = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: instruction sequences, reset abort,
// illegal opcode and counter wrap on a narrow instance.
module tb_multicycle_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, rst2_n;
  logic [5:0] op, op2;

  logic pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite;
  logic regwrite, regdst, alusrca, aluop1, aluop0, illegal;
  logic [1:0] alusrcb, pcsource;
  logic [3:0] state;
  logic [31:0] instret;

  logic pcwrite2, pcwritecond2, iord2, memread2, memwrite2, memtoreg2, irwrite2;
  logic regwrite2, regdst2, alusrca2, aluop12, aluop02, illegal2;
  logic [1:0] alusrcb2, pcsource2;
  logic [3:0] state2;
  logic [3:0] instret2;

  int checks = 0;
  int errors = 0;

  multicycle_control #(.INSTRET_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .op(op),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
    .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg),
    .irwrite(irwrite), .regwrite(regwrite), .regdst(regdst),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsource(pcsource),
    .aluop1(aluop1), .aluop0(aluop0), .illegal(illegal),
    .state(state), .instret(instret)
  );

  multicycle_control #(.INSTRET_W(4)) dut_w4 (
    .clk(clk), .rst_n(rst2_n), .op(op2),
    .pcwrite(pcwrite2), .pcwritecond(pcwritecond2), .iord(iord2),
    .memread(memread2), .memwrite(memwrite2), .memtoreg(memtoreg2),
    .irwrite(irwrite2), .regwrite(regwrite2), .regdst(regdst2),
    .alusrca(alusrca2), .alusrcb(alusrcb2), .pcsource(pcsource2),
    .aluop1(aluop12), .aluop0(aluop02), .illegal(illegal2),
    .state(state2), .instret(instret2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    op     = 6'b100011;
    op2    = 6'b000000;
    #2;
    check("reset_state", {28'd0, state}, 32'd0);
    check("reset_instret", instret, 32'd0);
    check("reset_memread_forced", {31'd0, memread}, 32'd0);
    check("reset_pcwrite_forced", {31'd0, pcwrite}, 32'd0);
    step();
    rst_n = 1'b1;
    #1;

    // lw: 0,1,2,3,4,0; op changed to sw during MEMADR must be ignored
    check("lw_fetch_state", {28'd0, state}, 32'd0);
    check("lw_fetch_ctrl", {28'd0, memread, irwrite, pcwrite, alusrcb == 2'b01}, 32'hF);
    step();
    check("lw_decode_state", {28'd0, state}, 32'd1);
    check("lw_decode_alusrcb", {30'd0, alusrcb}, 32'd3);
    check("lw_decode_illegal", {31'd0, illegal}, 32'd0);
    step();
    check("lw_memadr_state", {28'd0, state}, 32'd2);
    check("lw_memadr_ctrl", {29'd0, alusrca, alusrcb}, 32'b110);
    op = 6'b101011;
    step();
    check("lw_memrd_state", {28'd0, state}, 32'd3);
    check("lw_memrd_ctrl", {30'd0, memread, iord}, 32'b11);
    check("lw_memrd_regwrite", {31'd0, regwrite}, 32'd0);
    step();
    check("lw_memwb_state", {28'd0, state}, 32'd4);
    check("lw_memwb_ctrl", {29'd0, regwrite, memtoreg, memread}, 32'b110);
    step();
    check("lw_done_state", {28'd0, state}, 32'd0);
    check("lw_done_instret", instret, 32'd1);

    // R-type: 0,1,6,7,0
    op = 6'b000000;
    step();
    check("r_decode_state", {28'd0, state}, 32'd1);
    step();
    check("r_exec_state", {28'd0, state}, 32'd6);
    check("r_exec_aluop", {30'd0, aluop1, aluop0}, 32'b10);
    check("r_exec_alusrca", {31'd0, alusrca}, 32'd1);
    step();
    check("r_rtwb_state", {28'd0, state}, 32'd7);
    check("r_rtwb_ctrl", {29'd0, regdst, regwrite, memtoreg}, 32'b110);
    step();
    check("r_done_state", {28'd0, state}, 32'd0);
    check("r_done_instret", instret, 32'd2);

    // beq then j, 3 cycles each
    op = 6'b000100;
    step();
    step();
    check("beq_state", {28'd0, state}, 32'd8);
    check("beq_ctrl", {27'd0, pcwritecond, pcsource, aluop1, aluop0}, 32'b10101);
    check("beq_pcwrite", {31'd0, pcwrite}, 32'd0);
    step();
    check("beq_done_state", {28'd0, state}, 32'd0);
    op = 6'b000010;
    step();
    step();
    check("j_state", {28'd0, state}, 32'd9);
    check("j_ctrl", {29'd0, pcwrite, pcsource}, 32'b110);
    step();
    check("j_done_state", {28'd0, state}, 32'd0);
    check("branch_jump_instret", instret, 32'd4);

    // illegal opcode: DECODE only, no retire
    op = 6'b111111;
    check("illegal_fetch", {31'd0, illegal}, 32'd0);
    step();
    check("illegal_decode_state", {28'd0, state}, 32'd1);
    check("illegal_decode", {31'd0, illegal}, 32'd1);
    step();
    check("illegal_back_state", {28'd0, state}, 32'd0);
    check("illegal_after", {31'd0, illegal}, 32'd0);
    check("illegal_instret", instret, 32'd4);

    // addi: 0,1,10,11,0
    op = 6'b001000;
    step();
    step();
    check("addi_ex_state", {28'd0, state}, 32'd10);
    check("addi_ex_ctrl", {29'd0, alusrca, alusrcb}, 32'b110);
    step();
    check("addi_wb_state", {28'd0, state}, 32'd11);
    check("addi_wb_ctrl", {29'd0, regwrite, regdst, memtoreg}, 32'b100);
    step();
    check("addi_instret", instret, 32'd5);

    // sw aborted by reset in MEMWR
    op = 6'b101011;
    step();
    step();
    step();
    check("sw_memwr_state", {28'd0, state}, 32'd5);
    check("sw_memwr_ctrl", {30'd0, memwrite, iord}, 32'b11);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_memwrite", {31'd0, memwrite}, 32'd0);
    check("abort_state", {28'd0, state}, 32'd0);
    check("abort_instret", instret, 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    check("refetch_memread", {31'd0, memread}, 32'd1);
    step();
    check("refetch_decode", {28'd0, state}, 32'd1);

    // narrow counter wraps after 16 R-type instructions
    rst2_n = 1'b1;
    for (int i = 0; i < 64; i++) step();
    check("w4_after16_state", {28'd0, state2}, 32'd0);
    check("w4_after16_instret", {28'd0, instret2}, 32'd0);
    for (int i = 0; i < 4; i++) step();
    check("w4_after17_state", {28'd0, state2}, 32'd0);
    check("w4_after17_instret", {28'd0, instret2}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle MIPS datapath. It decodes the 6-bit opcode and steps each instruction through fetch, decode, execute, memory and writeback cycles. It drives the datapath enables, the mux selects and the `aluop1`/`aluop0` pair consumed directly by the ALU control decoder. It also counts retired instructions and flags unrecognised opcodes.

## Interface
- `INSTRET_W`, default 32: width of the retired-instruction counter.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `op`  in  6  opcode, IR[31:26]; sampled only in DECODE
- `pcwrite`, `pcwritecond`, `iord`, `memread`, `memwrite`, `memtoreg`, `irwrite`, `regwrite`, `regdst`, `alusrca`  out  1 each  datapath controls
- `alusrcb`  out  2  ALU B select: 00 reg B, 01 constant 4, 10 sign-extended immediate, 11 shifted sign-extended immediate
- `pcsource`  out  2  PC select: 00 ALU result, 01 ALUOut, 10 jump target
- `aluop1`, `aluop0`  out  1 each  to ALU control: 00 add, 01 subtract, 10 R-type function decode
- `illegal`  out  1  high in DECODE when `op` is unrecognised
- `state`  out  4  current state encoding, for debug
- `instret`  out  INSTRET_W  retired-instruction count

## Operation
- Opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - j 000010
  - addi 001000
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RTWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11.
- Unused encodings 12-15 go to FETCH on the next edge. All outputs are 0 in these states.
- Transitions:
  - FETCH→DECODE.
  - DECODE→ by `op`: lw/sw→MEMADR, R→EXEC, beq→BRANCH, j→JUMP, addi→ADDIEX; any other `op`→FETCH.
  - MEMADR→MEMRD (lw) or MEMWR (sw). The opcode is latched in DECODE; `op` is not re-sampled.
  - MEMRD→MEMWB; EXEC→RTWB; ADDIEX→ADDIWB.
  - MEMWB, MEMWR, RTWB, BRANCH, JUMP, ADDIWB → FETCH.
- Moore outputs, decoded from `state`. Every signal not listed for a state is 0.
  - FETCH: memread, irwrite, pcwrite = 1; alusrcb = 01.
  - DECODE: alusrcb = 11.
  - MEMADR: alusrca = 1; alusrcb = 10.
  - MEMRD: memread, iord = 1.
  - MEMWB: regwrite, memtoreg = 1.
  - MEMWR: memwrite, iord = 1.
  - EXEC: alusrca = 1; aluop1 = 1.
  - RTWB: regwrite, regdst = 1.
  - BRANCH: alusrca, aluop0, pcwritecond = 1; pcsource = 01.
  - JUMP: pcwrite = 1; pcsource = 10.
  - ADDIEX: alusrca = 1; alusrcb = 10.
  - ADDIWB: regwrite = 1.
- `illegal` is the only output that depends on `op`: state == DECODE and `op` is not one of the six opcodes above.
- `instret`:
  - Increments by 1 on each edge leaving MEMWB, MEMWR, RTWB, BRANCH, JUMP or ADDIWB.
  - Wraps modulo 2^INSTRET_W.
  - An illegal opcode does not retire and does not increment it.

## Timing
- Reset (`rst_n` low, asynchronous):
  - `state` = FETCH and `instret` = 0 immediately.
  - While `rst_n` is low, all control outputs and `illegal` are forced to 0; `state` reads 0.
- First edge after `rst_n` rises: the FETCH outputs are already active in the cycle before that edge.
- Cycles per instruction, counted from FETCH to the next FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Asserting `rst_n` low mid-instruction, including in MEMWR or RTWB, drops writes in the same cycle. The interrupted instruction does not retire.
- `op` changing outside DECODE has no effect.
- The state register and `instret` update on the same edge.

## Test plan
- Reset, then `op` = 100011 held → state sequence 0,1,2,3,4,0. `memread` = 1 in states 0 and 3. `regwrite` and `memtoreg` = 1 in state 4 only. `instret` = 1 after the return to FETCH.
- `op` = 000000 → sequence 0,1,6,7,0. In state 6, {aluop1, aluop0} = 10. In state 7, `regdst` and `regwrite` = 1. `instret` increments by 1.
- `op` = 000100 then 000010 → beq: state 8 with `pcwritecond` = 1, `pcsource` = 01, {aluop1, aluop0} = 01. j: state 9 with `pcwrite` = 1, `pcsource` = 10. Each takes 3 cycles; `instret` rises by 2 in total.
- `op` = 111111 → `illegal` = 1 during DECODE only, then FETCH. `instret` unchanged. Total 2 cycles.
- Start sw (`op` = 101011) and pull `rst_n` low in state 5 → `memwrite` falls in the same cycle. `state` = 0 and `instret` = 0 immediately. After release, a fresh fetch begins.
- Instantiate with INSTRET_W = 4 and run 17 R-type instructions → `instret` wraps to 1.
